// File: rtl/lsu_mem_req.sv
// rtl/lsu_mem_req.sv - load/store request sequencer driving a single-cycle memory strobe
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned requests return a trap response)
module lsu_mem_req #(
    parameter int LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_misalign,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    input  logic [63:0] mem_rdata,
    output logic [7:0]  mem_wmask,
    output logic [63:0] mem_wdata
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        r_wen, r_unsigned;
    logic [1:0]  r_size;
    logic [63:0] r_addr, r_wdata;

    logic        accept, trap;
    logic [2:0]  size_mask;
    logic [63:0] req_addr_al;
    logic        s_wen;
    logic [1:0]  s_size;
    logic [63:0] s_addr, s_wdata;
    logic [7:0]  s_bytes;
    logic [63:0] ld_shift, ld_ext;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    always_comb begin
        size_mask = 3'b000;
        case (req_size)
            2'd1:    size_mask = 3'b001;
            2'd2:    size_mask = 3'b011;
            2'd3:    size_mask = 3'b111;
            default: size_mask = 3'b000;
        endcase
    end

    // Offset is forced to size alignment so an access can never straddle a word
    assign req_addr_al = {req_addr[63:3], req_addr[2:0] & ~size_mask};

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = (req_addr[2:0] & size_mask) != 3'b000;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (trap)              state_nxt = RESP;
                    else if (LATENCY == 0) state_nxt = ACCESS;
                    else                   state_nxt = WAIT;
                end
            end
            WAIT:    if (cnt == 4'd0) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A zero-latency accept loads the strobe registers straight from the request port
    always_comb begin
        if (state == IDLE) begin
            s_wen   = req_wen;
            s_size  = req_size;
            s_addr  = req_addr_al;
            s_wdata = req_wdata;
        end else begin
            s_wen   = r_wen;
            s_size  = r_size;
            s_addr  = r_addr;
            s_wdata = r_wdata;
        end
        case (s_size)
            2'd0:    s_bytes = 8'h01;
            2'd1:    s_bytes = 8'h03;
            2'd2:    s_bytes = 8'h0F;
            default: s_bytes = 8'hFF;
        endcase
    end

    always_comb begin
        ld_shift = mem_rdata >> {r_addr[2:0], 3'b000};
        case (r_size)
            2'd0:    ld_ext = r_unsigned ? {56'd0, ld_shift[7:0]}  : {{56{ld_shift[7]}},  ld_shift[7:0]};
            2'd1:    ld_ext = r_unsigned ? {48'd0, ld_shift[15:0]} : {{48{ld_shift[15]}}, ld_shift[15:0]};
            2'd2:    ld_ext = r_unsigned ? {32'd0, ld_shift[31:0]} : {{32{ld_shift[31]}}, ld_shift[31:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            r_wen         <= 1'b0;
            r_unsigned    <= 1'b0;
            r_size        <= 2'd0;
            r_addr        <= 64'd0;
            r_wdata       <= 64'd0;
            resp_rdata    <= 64'd0;
            resp_misalign <= 1'b0;
            mem_ren       <= 1'b0;
            mem_wen       <= 1'b0;
            mem_addr      <= 64'd0;
            mem_wmask     <= 8'd0;
            mem_wdata     <= 64'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_wen      <= req_wen;
                r_unsigned <= req_unsigned;
                r_size     <= req_size;
                r_addr     <= req_addr_al;
                r_wdata    <= req_wdata;
                cnt        <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state_nxt == ACCESS) begin
                mem_ren   <= ~s_wen;
                mem_wen   <= s_wen;
                mem_addr  <= {s_addr[63:3], 3'b000};
                mem_wmask <= s_wen ? (s_bytes << s_addr[2:0]) : 8'h00;
                mem_wdata <= s_wen ? (s_wdata << {s_addr[2:0], 3'b000}) : 64'd0;
            end else begin
                mem_ren   <= 1'b0;
                mem_wen   <= 1'b0;
                mem_addr  <= 64'd0;
                mem_wmask <= 8'd0;
                mem_wdata <= 64'd0;
            end
            if (state == ACCESS) begin
                resp_rdata    <= r_wen ? 64'd0 : ld_ext;
                resp_misalign <= 1'b0;
            end else if (accept && trap) begin
                resp_rdata    <= 64'd0;
                resp_misalign <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_req.sv
// tb/tb_lsu_mem_req.sv - randomized bench for lsu_mem_req against a byte-level memory model
module tb_lsu_mem_req;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_wen = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
    logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
    logic [1:0]  req_size = 2'd0;
    logic        vin0, vin1;
    logic        rr [2], rv [2], rmis [2], mren [2], mwen [2];
    logic [63:0] rdat [2], maddr [2], mwdat [2], mrd [2];
    logic [7:0]  mmask [2];
    logic [63:0] tmem [16];
    byte unsigned ref_mem [128];

    int tests_run = 0, tests_failed = 0;
    int o_scyc, o_nstr, o_rcyc;
    logic o_sren, o_swen, o_mis, o_stable, o_rdybad, o_rdyafter, o_timeout;
    logic [63:0] o_maddr, o_mwdata, o_rdata;
    logic [7:0]  o_mask;

    always #5 clock = ~clock;

    assign vin0   = req_valid & ~sel;
    assign vin1   = req_valid & sel;
    assign mrd[0] = tmem[maddr[0][6:3]];
    assign mrd[1] = tmem[maddr[1][6:3]];

    always @(posedge clock)
        for (int d = 0; d < 2; d++)
            if (mwen[d])
                for (int b = 0; b < 8; b++)
                    if (mmask[d][b]) tmem[maddr[d][6:3]][8*b +: 8] <= mwdat[d][8*b +: 8];

    lsu_mem_req #(.LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset), .req_valid(vin0), .req_ready(rr[0]), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_rdata(rdat[0]), .resp_misalign(rmis[0]),
        .mem_ren(mren[0]), .mem_wen(mwen[0]), .mem_addr(maddr[0]), .mem_rdata(mrd[0]),
        .mem_wmask(mmask[0]), .mem_wdata(mwdat[0]));

    lsu_mem_req #(.LATENCY(3)) u_dut3 (
        .clock(clock), .reset(reset), .req_valid(vin1), .req_ready(rr[1]), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_rdata(rdat[1]), .resp_misalign(rmis[1]),
        .mem_ren(mren[1]), .mem_wen(mwen[1]), .mem_addr(maddr[1]), .mem_rdata(mrd[1]),
        .mem_wmask(mmask[1]), .mem_wdata(mwdat[1]));

    function automatic logic [63:0] ref_load(input logic [63:0] ea, input int n, input logic u);
        logic [63:0] v;
        int off;
        v = 64'd0;
        off = int'(ea - BASE);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[off + i];
        if (!u && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    task automatic init_mem();
        logic [63:0] w;
        for (int i = 0; i < 16; i++) begin
            w = (i == 0) ? 64'h8877665544332211 : {$urandom, $urandom};
            tmem[i] <= w;
            for (int b = 0; b < 8; b++) ref_mem[i*8 + b] = w[8*b +: 8];
        end
        #1;
    endtask

    task automatic run_txn(input logic s, input logic w, input logic [63:0] a, input logic [1:0] sz,
                           input logic u, input logic [63:0] wd, input int hold, input logic spam);
        int k, waited;
        logic done;
        sel = s; req_wen = w; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
        req_valid = 1'b1;
        o_scyc = 0; o_nstr = 0; o_rcyc = 0; o_sren = 0; o_swen = 0; o_mis = 0; o_stable = 1;
        o_rdybad = 0; o_maddr = 0; o_mwdata = 0; o_rdata = 0; o_mask = 0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        k = 0; waited = 0; done = 0;
        while (!done && k < 60) begin
            @(negedge clock);
            k++;
            if (mren[sel] || mwen[sel]) begin
                o_nstr++;
                if (o_nstr == 1) begin
                    o_scyc = k; o_sren = mren[sel]; o_swen = mwen[sel];
                    o_maddr = maddr[sel]; o_mask = mmask[sel]; o_mwdata = mwdat[sel];
                end
            end
            if (rr[sel]) o_rdybad = 1;
            if (rv[sel]) begin
                if (o_rcyc == 0) begin
                    o_rcyc = k; o_rdata = rdat[sel]; o_mis = rmis[sel];
                end else if (rdat[sel] !== o_rdata || rmis[sel] !== o_mis) o_stable = 0;
                if (waited < hold) begin
                    waited++;
                    req_valid = spam;
                    req_wen = 1'($urandom_range(0, 1));
                    req_addr = BASE + 64'($urandom_range(0, 127));
                end else begin
                    req_valid = 1'b0;
                    resp_ready = 1'b1;
                    @(posedge clock);
                    #1 resp_ready = 1'b0;
                    done = 1;
                end
            end
        end
        o_timeout = !done;
        @(negedge clock);
        o_rdyafter = rr[sel];
        if (mren[sel] || mwen[sel]) o_nstr++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            tests_run++; if ({rr[d], rv[d], mren[d], mwen[d], rmis[d]} !== 5'b10000) begin tests_failed++; $display("FAIL reset_ctl[%0d] got %b exp 10000", d, {rr[d], rv[d], mren[d], mwen[d], rmis[d]}); end
            tests_run++; if ((maddr[d] | mwdat[d] | rdat[d] | 64'(mmask[d])) !== 64'd0) begin tests_failed++; $display("FAIL reset_data[%0d] got %h exp 0", d, maddr[d] | mwdat[d] | rdat[d]); end
        end
        reset = 1'b0;
    endtask

    task automatic test_loads();
        run_txn(0, 0, BASE + 64'd4, 2'd2, 0, 64'd0, 0, 0);
        tests_run++; if (o_rdata !== 64'hFFFFFFFF88776655) begin tests_failed++; $display("FAIL lw_data got %h exp ffffffff88776655", o_rdata); end
        tests_run++; if (o_scyc !== 2 || o_rcyc !== 3) begin tests_failed++; $display("FAIL lw_timing got strobe %0d resp %0d exp 2 3", o_scyc, o_rcyc); end
        tests_run++; if (o_nstr !== 1 || o_sren !== 1'b1 || o_maddr !== BASE) begin tests_failed++; $display("FAIL lw_strobe got n=%0d ren=%b addr=%h exp 1 1 %h", o_nstr, o_sren, o_maddr, BASE); end
        run_txn(0, 0, BASE + 64'd7, 2'd0, 1, 64'd0, 0, 0);
        tests_run++; if (o_rdata !== 64'h88) begin tests_failed++; $display("FAIL lbu_data got %h exp 88", o_rdata); end
        run_txn(0, 0, BASE + 64'd2, 2'd1, 0, 64'd0, 0, 0);
        tests_run++; if (o_rdata !== 64'h4433) begin tests_failed++; $display("FAIL lh_data got %h exp 4433", o_rdata); end
    endtask

    task automatic test_store();
        run_txn(0, 1, BASE + 64'd2, 2'd1, 0, 64'hABCD, 0, 0);
        ref_mem[2] = 8'hCD; ref_mem[3] = 8'hAB;
        tests_run++; if (o_swen !== 1'b1 || o_sren !== 1'b0 || o_nstr !== 1) begin tests_failed++; $display("FAIL sh_strobe got wen=%b ren=%b n=%0d exp 1 0 1", o_swen, o_sren, o_nstr); end
        tests_run++; if (o_maddr !== BASE || o_mask !== 8'h0C) begin tests_failed++; $display("FAIL sh_addr_mask got %h %h exp %h 0c", o_maddr, o_mask, BASE); end
        tests_run++; if (o_mwdata !== 64'hABCD0000 || o_rdata !== 64'd0) begin tests_failed++; $display("FAIL sh_wdata got %h rdata %h exp abcd0000 0", o_mwdata, o_rdata); end
        run_txn(0, 0, BASE, 2'd2, 0, 64'd0, 0, 0);
        tests_run++; if (o_rdata !== 64'hFFFFFFFFABCD2211) begin tests_failed++; $display("FAIL sh_readback got %h exp ffffffffabcd2211", o_rdata); end
    endtask

    task automatic test_latency();
        logic [63:0] exp;
        exp = ref_load(BASE + 64'd8, 8, 0);
        run_txn(1, 0, BASE + 64'd8, 2'd3, 0, 64'd0, 0, 0);
        tests_run++; if (o_scyc !== 4 || o_rcyc !== 5) begin tests_failed++; $display("FAIL lat3_timing got strobe %0d resp %0d exp 4 5", o_scyc, o_rcyc); end
        tests_run++; if (o_rdybad !== 1'b0 || o_nstr !== 1) begin tests_failed++; $display("FAIL lat3_ready got rdybad=%b n=%0d exp 0 1", o_rdybad, o_nstr); end
        tests_run++; if (o_rdata !== exp) begin tests_failed++; $display("FAIL lat3_data got %h exp %h", o_rdata, exp); end
    endtask

    task automatic test_back_to_back_hold();
        logic [63:0] exp;
        exp = ref_load(BASE + 64'd20, 4, 1);
        run_txn(0, 0, BASE + 64'd20, 2'd2, 1, 64'd0, 4, 1);
        tests_run++; if (o_stable !== 1'b1 || o_rdata !== exp) begin tests_failed++; $display("FAIL hold_data got stable=%b %h exp 1 %h", o_stable, o_rdata, exp); end
        tests_run++; if (o_nstr !== 1 || o_rdybad !== 1'b0) begin tests_failed++; $display("FAIL hold_strobe got n=%0d rdybad=%b exp 1 0", o_nstr, o_rdybad); end
        tests_run++; if (o_rdyafter !== 1'b1 || o_timeout !== 1'b0) begin tests_failed++; $display("FAIL hold_after got ready=%b timeout=%b exp 1 0", o_rdyafter, o_timeout); end
    endtask

    task automatic test_misalign();
        init_mem();
        run_txn(0, 0, BASE + 64'd2, 2'd2, 0, 64'd0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        tests_run++; if (o_rcyc !== 1 || o_mis !== 1'b1) begin tests_failed++; $display("FAIL mis_trap got resp %0d mis %b exp 1 1", o_rcyc, o_mis); end
        tests_run++; if (o_nstr !== 0 || o_rdata !== 64'd0) begin tests_failed++; $display("FAIL mis_nostrobe got n=%0d rdata %h exp 0 0", o_nstr, o_rdata); end
`else
        tests_run++; if (o_maddr !== BASE || o_mis !== 1'b0) begin tests_failed++; $display("FAIL mis_addr got %h mis %b exp %h 0", o_maddr, o_mis, BASE); end
        tests_run++; if (o_rdata !== 64'h44332211 || o_rcyc !== 3) begin tests_failed++; $display("FAIL mis_data got %h resp %0d exp 44332211 3", o_rdata, o_rcyc); end
`endif
    endtask

    task automatic test_reset_mid();
        logic bad;
        sel = 1; req_wen = 0; req_addr = BASE + 64'd40; req_size = 2'd3; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clock);
        tests_run++; if (rr[1] !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got ready %b exp 0", rr[1]); end
        #2 reset = 1'b1;
        #1;
        tests_run++; if (rr[1] !== 1'b1 || rv[1] !== 1'b0) begin tests_failed++; $display("FAIL rst_async got ready %b valid %b exp 1 0", rr[1], rv[1]); end
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (mren[1] || mwen[1] || rv[1]) bad = 1;
        end
        tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("FAIL rst_abandon got activity %b exp 0", bad); end
    endtask

    task automatic test_random(input int count);
        for (int t = 0; t < count; t++) begin
            logic s, w, u, mis;
            logic [1:0] sz;
            logic [63:0] a, ea, wd, exp_rd, exp_wd;
            logic [7:0] exp_mask;
            int n, lat, hold;
            s = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3)); wd = {$urandom, $urandom};
            hold = $urandom_range(0, 2);
            n = 1 << sz;
            a = BASE + 64'($urandom_range(0, 127));
            ea = a & ~64'(n - 1);
`ifdef LSU_MISALIGN_TRAP_EN
            mis = (a % 64'(n)) != 64'd0;
`else
            mis = 1'b0;
`endif
            lat = s ? 3 : 1;
            exp_rd = 64'd0; exp_wd = 64'd0; exp_mask = 8'd0;
            if (!mis && !w) exp_rd = ref_load(ea, n, u);
            if (!mis && w) begin
                exp_mask = 8'((1 << n) - 1) << ea[2:0];
                exp_wd = wd << (8 * ea[2:0]);
                for (int i = 0; i < n; i++) ref_mem[int'(ea - BASE) + i] = wd[8*i +: 8];
            end
            run_txn(s, w, a, sz, u, wd, hold, 1'($urandom_range(0, 1)));
            tests_run++; if (o_rdata !== exp_rd || o_mis !== mis) begin tests_failed++; $display("FAIL rand%0d_resp got %h mis %b exp %h %b", t, o_rdata, o_mis, exp_rd, mis); end
            tests_run++; if (o_rcyc !== (mis ? 1 : lat + 2) || o_nstr !== (mis ? 0 : 1)) begin tests_failed++; $display("FAIL rand%0d_timing got resp %0d n=%0d", t, o_rcyc, o_nstr); end
            if (!mis) begin
                tests_run++; if (o_scyc !== lat + 1 || o_maddr !== (ea & ~64'd7) || o_swen !== w || o_sren !== !w) begin tests_failed++; $display("FAIL rand%0d_strobe got cyc %0d addr %h wen %b exp %0d %h %b", t, o_scyc, o_maddr, o_swen, lat + 1, ea & ~64'd7, w); end
                if (w) begin
                    tests_run++; if (o_mask !== exp_mask || o_mwdata !== exp_wd) begin tests_failed++; $display("FAIL rand%0d_wr got %h %h exp %h %h", t, o_mask, o_mwdata, exp_mask, exp_wd); end
                end
            end
        end
    endtask

    initial begin
        init_mem();
        test_reset();
        test_loads();
        test_store();
        test_latency();
        test_back_to_back_hold();
        test_misalign();
        test_reset_mid();
        test_random(40);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
